// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program-counter unit.
package pc_pkg;

  // Two-state run/halt controller.
  typedef enum logic {
    PC_RUN    = 1'b0,
    PC_HALTED = 1'b1
  } pc_state_e;

  // Select for the next-PC multiplexer.
  typedef logic [2:0] pc_src_t;
  localparam pc_src_t SRC_HOLD = 3'd0;
  localparam pc_src_t SRC_INC  = 3'd1;
  localparam pc_src_t SRC_BR   = 3'd2;
  localparam pc_src_t SRC_JMP  = 3'd3;
  localparam pc_src_t SRC_RET  = 3'd4;

  // Index width for a stack of the given depth (at least one bit).
  function automatic int unsigned ras_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: small LIFO with full/empty flags and
// single-cycle overflow/underflow pulses for the owner to latch.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int unsigned PTR_W = ras_ptr_w(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  top_idx;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(RAS_DEPTH));
  assign empty_o = (count_q == '0);
  assign top_idx = PTR_W'(count_q - 1'b1);
  assign top_o   = mem_q[top_idx];

  // Pop wins if both are requested; a refused push/pop only raises a pulse.
  assign do_pop      = pop_i && !empty_o;
  assign do_push     = push_i && !pop_i && !full_o;
  assign overflow_o  = push_i && !pop_i && full_o;
  assign underflow_o = pop_i && empty_o;

  // Occupancy count next-state.
  always_comb begin
    // NOTE: give every combinationally driven signal a default first so no path leaves it unassigned (that would infer a latch).
    count_d = count_q;
    if (do_pop)       count_d = count_q - 1'b1;
    else if (do_push) count_d = count_q + 1'b1;
  end

  // Occupancy count register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // Entry storage, written at the current count position on push.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the count alone decides which entries are valid.
    if (do_push) mem_q[count_q[PTR_W-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: increment, jump, relative branch,
// call/return through a return-address stack, stall and halt/resume.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 10,
  parameter int unsigned       RAS_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [ADDR_W-1:0] STEP       = ADDR_W'(1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              br_en,
  input  logic [ADDR_W-1:0] br_off,
  input  logic              call_en,
  input  logic              ret_en,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_err
);

  pc_state_e         state_q, state_d;
  pc_src_t           src;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, ras_top;
  logic              ras_push, ras_pop, ras_ovf, ras_unf;
  logic              ras_err_q, ras_err_d;
  logic              active;

  assign pc_inc = pc_q + STEP;
  // Control inputs only act in RUN with no halt request and no stall.
  assign active = (state_q == PC_RUN) && !halt_req && !stall;

  pc_ras #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .reset      (reset),
    .push_i     (ras_push),
    .pop_i      (ras_pop),
    .push_data_i(pc_inc),
    .top_o      (ras_top),
    .full_o     (ras_full),
    .empty_o    (ras_empty),
    .overflow_o (ras_ovf),
    .underflow_o(ras_unf)
  );

  // Run/halt state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= PC_RUN;
    else       state_q <= state_d;
  end

  // Run/halt next state; a pending halt request beats resume.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PC_RUN:    if (halt_req) state_d = PC_HALTED;
      PC_HALTED: if (resume && !halt_req) state_d = PC_RUN;
      default:   state_d = PC_RUN;
    endcase
  end

  // Control decode: priority ret > call > jmp > br > increment.
  always_comb begin
    src      = SRC_HOLD;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (active) begin
      if (ret_en) begin
        ras_pop = 1'b1;
        src     = ras_empty ? SRC_INC : SRC_RET;
      end else if (call_en) begin
        ras_push = 1'b1;
        src      = SRC_JMP;
      end else if (jmp_en) begin
        src = SRC_JMP;
      end else if (br_en) begin
        src = SRC_BR;
      end else begin
        src = SRC_INC;
      end
    end
  end

  // Next-PC multiplexer; all sums wrap modulo 2^ADDR_W.
  always_comb begin
    unique case (src)
      SRC_INC: pc_d = pc_inc;
      SRC_BR:  pc_d = pc_q + br_off;
      SRC_JMP: pc_d = jmp_addr;
      SRC_RET: pc_d = ras_top;
      default: pc_d = pc_q;
    endcase
  end

  assign ras_err_d = ras_err_q || ras_ovf || ras_unf;

  // PC and sticky stack-error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_ADDR;
      ras_err_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ras_err_q <= ras_err_d;
    end
  end

  assign pc_out  = pc_q;
  assign halted  = (state_q == PC_HALTED);
  assign ras_err = ras_err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: a table of per-cycle vectors is
// driven on the falling edge, expectations go into a scoreboard queue,
// and are compared against the DUT on the next falling edge.
module tb_pc_unit;

  localparam int unsigned W = 10;

  logic         clk = 1'b0;
  logic         reset, stall, halt_req, resume, jmp_en, br_en, call_en, ret_en;
  logic [W-1:0] jmp_addr, br_off, pc_out;
  logic         halted, ras_empty, ras_full, ras_err;

  always #5 clk = ~clk;

  pc_unit #(
    .ADDR_W    (W),
    .RAS_DEPTH (4),
    .RESET_ADDR(10'd0),
    .STEP      (10'd1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .halt_req (halt_req),
    .resume   (resume),
    .jmp_en   (jmp_en),
    .jmp_addr (jmp_addr),
    .br_en    (br_en),
    .br_off   (br_off),
    .call_en  (call_en),
    .ret_en   (ret_en),
    .pc_out   (pc_out),
    .halted   (halted),
    .ras_empty(ras_empty),
    .ras_full (ras_full),
    .ras_err  (ras_err)
  );

  typedef struct {
    string        name;
    logic         rst, hr, rs, st, jmp;
    logic [W-1:0] ja;
    logic         br;
    logic [W-1:0] bo;
    logic         call, ret;
    logic [W-1:0] e_pc;
    logic         e_h, e_e, e_f, e_err;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic void add(input string nm,
                              input logic rst, hr, rs, st, jmp, input logic [W-1:0] ja,
                              input logic br, input logic [W-1:0] bo, input logic call, ret,
                              input logic [W-1:0] epc, input logic eh, ee, ef, eerr);
    vec_t v;
    v.name = nm; v.rst = rst; v.hr = hr; v.rs = rs; v.st = st; v.jmp = jmp; v.ja = ja;
    v.br = br; v.bo = bo; v.call = call; v.ret = ret;
    v.e_pc = epc; v.e_h = eh; v.e_e = ee; v.e_f = ef; v.e_err = eerr;
    vecs.push_back(v);
  endfunction

  task automatic drive(input vec_t v);
    reset    = v.rst;
    halt_req = v.hr;
    resume   = v.rs;
    stall    = v.st;
    jmp_en   = v.jmp;
    jmp_addr = v.ja;
    br_en    = v.br;
    br_off   = v.bo;
    call_en  = v.call;
    ret_en   = v.ret;
  endtask

  task automatic check();
    vec_t v;
    if (sb.size() > 0) begin
      v = sb.pop_front();
      n_vec++;
      if (pc_out !== v.e_pc || halted !== v.e_h || ras_empty !== v.e_e ||
          ras_full !== v.e_f || ras_err !== v.e_err) begin
        n_miss++;
        $display("FAIL %s: got pc=%0d halted=%b empty=%b full=%b err=%b, want pc=%0d halted=%b empty=%b full=%b err=%b",
                 v.name, pc_out, halted, ras_empty, ras_full, ras_err,
                 v.e_pc, v.e_h, v.e_e, v.e_f, v.e_err);
      end
    end
  endtask

  initial begin
    reset = 1'b1; halt_req = 1'b0; resume = 1'b0; stall = 1'b0; jmp_en = 1'b0;
    jmp_addr = '0; br_en = 1'b0; br_off = '0; call_en = 1'b0; ret_en = 1'b0;

    //   name            rst hr rs st jmp ja     br bo      call ret | pc   h  e  f  err
    add("reset0",        1, 0, 0, 0, 0, 10'd0,   0, 10'd0,  0, 0,  10'd0,   0, 1, 0, 0);
    add("reset1",        1, 0, 0, 0, 0, 10'd0,   0, 10'd0,  0, 0,  10'd0,   0, 1, 0, 0);
    for (int k = 1; k <= 5; k++)
      add("idle_inc",    0, 0, 0, 0, 0, 10'd0,   0, 10'd0,  0, 0,  W'(k),   0, 1, 0, 0);
    add("jmp_1023",      0, 0, 0, 0, 1, 10'd1023,0, 10'd0,  0, 0,  10'd1023,0, 1, 0, 0);
    add("inc_wrap",      0, 0, 0, 0, 0, 10'd0,   0, 10'd0,  0, 0,  10'd0,   0, 1, 0, 0);
    add("jmp_20",        0, 0, 0, 0, 1, 10'd20,  0, 10'd0,  0, 0,  10'd20,  0, 1, 0, 0);
    add("br_neg4",       0, 0, 0, 0, 0, 10'd0,   1, 10'h3FC,0, 0,  10'd16,  0, 1, 0, 0);
    add("jmp_over_br",   0, 0, 0, 0, 1, 10'd100, 1, 10'd5,  0, 0,  10'd100, 0, 1, 0, 0);
    add("jmp_10",        0, 0, 0, 0, 1, 10'd10,  0, 10'd0,  0, 0,  10'd10,  0, 1, 0, 0);
    add("call_200",      0, 0, 0, 0, 0, 10'd200, 0, 10'd0,  1, 0,  10'd200, 0, 0, 0, 0);
    for (int k = 201; k <= 203; k++)
      add("inc_in_sub",  0, 0, 0, 0, 0, 10'd0,   0, 10'd0,  0, 0,  W'(k),   0, 0, 0, 0);
    add("call_300",      0, 0, 0, 0, 0, 10'd300, 0, 10'd0,  1, 0,  10'd300, 0, 0, 0, 0);
    add("ret_to_204",    0, 0, 0, 0, 0, 10'd0,   0, 10'd0,  0, 1,  10'd204, 0, 0, 0, 0);
    add("ret_to_11",     0, 0, 0, 0, 0, 10'd0,   0, 10'd0,  0, 1,  10'd11,  0, 1, 0, 0);
    add("nest_call1",    0, 0, 0, 0, 0, 10'd100, 0, 10'd0,  1, 0,  10'd100, 0, 0, 0, 0);
    add("nest_call2",    0, 0, 0, 0, 0, 10'd110, 0, 10'd0,  1, 0,  10'd110, 0, 0, 0, 0);
    add("nest_call3",    0, 0, 0, 0, 0, 10'd120, 0, 10'd0,  1, 0,  10'd120, 0, 0, 0, 0);
    add("nest_call4",    0, 0, 0, 0, 0, 10'd130, 0, 10'd0,  1, 0,  10'd130, 0, 0, 1, 0);
    add("call_overflow", 0, 0, 0, 0, 0, 10'd140, 0, 10'd0,  1, 0,  10'd140, 0, 0, 1, 1);
    add("nest_ret1",     0, 0, 0, 0, 0, 10'd0,   0, 10'd0,  0, 1,  10'd121, 0, 0, 0, 1);
    add("nest_ret2",     0, 0, 0, 0, 0, 10'd0,   0, 10'd0,  0, 1,  10'd111, 0, 0, 0, 1);
    add("nest_ret3",     0, 0, 0, 0, 0, 10'd0,   0, 10'd0,  0, 1,  10'd101, 0, 0, 0, 1);
    add("nest_ret4",     0, 0, 0, 0, 0, 10'd0,   0, 10'd0,  0, 1,  10'd12,  0, 1, 0, 1);
    add("ret_underflow", 0, 0, 0, 0, 0, 10'd0,   0, 10'd0,  0, 1,  10'd13,  0, 1, 0, 1);
    add("call_over_br",  0, 0, 0, 0, 0, 10'd60,  1, 10'd5,  1, 0,  10'd60,  0, 0, 0, 1);
    add("ret_over_call", 0, 0, 0, 0, 0, 10'd70,  0, 10'd0,  1, 1,  10'd14,  0, 1, 0, 1);
    add("err_sticky",    0, 0, 0, 0, 0, 10'd0,   0, 10'd0,  0, 0,  10'd15,  0, 1, 0, 1);
    add("reset_clr_err", 1, 0, 0, 0, 0, 10'd0,   0, 10'd0,  0, 0,  10'd0,   0, 1, 0, 0);
    add("jmp_40",        0, 0, 0, 0, 1, 10'd40,  0, 10'd0,  0, 0,  10'd40,  0, 1, 0, 0);
    add("halt_enter",    0, 1, 0, 0, 0, 10'd0,   0, 10'd0,  0, 0,  10'd40,  1, 1, 0, 0);
    for (int k = 0; k < 10; k++)
      add("halt_frozen", 0, 0, 0, 0, 1, 10'd99,  0, 10'd0,  0, 0,  10'd40,  1, 1, 0, 0);
    add("resume",        0, 0, 1, 0, 0, 10'd0,   0, 10'd0,  0, 0,  10'd40,  0, 1, 0, 0);
    add("after_resume",  0, 0, 0, 0, 0, 10'd0,   0, 10'd0,  0, 0,  10'd41,  0, 1, 0, 0);
    add("halt_in_stall", 0, 1, 0, 1, 1, 10'd99,  0, 10'd0,  0, 0,  10'd41,  1, 1, 0, 0);
    add("resume_vs_hr",  0, 1, 1, 0, 0, 10'd0,   0, 10'd0,  0, 0,  10'd41,  1, 1, 0, 0);
    add("resume2",       0, 0, 1, 0, 0, 10'd0,   0, 10'd0,  0, 0,  10'd41,  0, 1, 0, 0);
    add("after_resume2", 0, 0, 0, 0, 0, 10'd0,   0, 10'd0,  0, 0,  10'd42,  0, 1, 0, 0);
    for (int k = 0; k < 3; k++)
      add("stall_call",  0, 0, 0, 1, 0, 10'd300, 0, 10'd0,  1, 0,  10'd42,  0, 1, 0, 0);
    add("after_stall",   0, 0, 0, 0, 0, 10'd0,   0, 10'd0,  0, 0,  10'd43,  0, 1, 0, 0);
    add("pre_call_200",  0, 0, 0, 0, 0, 10'd200, 0, 10'd0,  1, 0,  10'd200, 0, 0, 0, 0);
    add("pre_call_210",  0, 0, 0, 0, 0, 10'd210, 0, 10'd0,  1, 0,  10'd210, 0, 0, 0, 0);
    add("halt_with_ras", 0, 1, 0, 0, 0, 10'd0,   0, 10'd0,  0, 0,  10'd210, 1, 0, 0, 0);
    add("halt_ignr_ret", 0, 0, 0, 0, 0, 10'd0,   0, 10'd0,  0, 1,  10'd210, 1, 0, 0, 0);
    add("reset_halted",  1, 1, 0, 0, 0, 10'd0,   0, 10'd0,  0, 0,  10'd0,   0, 1, 0, 0);
    add("run_after_rst", 0, 0, 0, 0, 0, 10'd0,   0, 10'd0,  0, 0,  10'd1,   0, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      check();
      drive(vecs[i]);
      sb.push_back(vecs[i]);
    end
    @(negedge clk);
    check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
